// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared state encoding and timing defaults for key_debounce
//
// Purpose : state encoding for the debounce FSM, default timing constants,
//           and a helper that sizes the shared counter.
// Contents: state_e, DEF_DEBOUNCE_N, DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD, max3()

package key_debounce_pkg;

  // Fixed 3-bit encoding so the state can be probed or compared externally.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_REPEAT       = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } state_e;

  // Defaults sized for a 50 MHz clock: 10 ms debounce, 0.5 s delay, 10 Hz repeat.
  localparam int unsigned DEF_DEBOUNCE_N    = 500000;
  localparam int unsigned DEF_REPEAT_DELAY  = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 5000000;

  // Largest of three values; the single counter must reach every terminal.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce_sync2.sv
// rtl/key_debounce_sync2.sv - two-flop synchroniser for an asynchronous button input
//
// Purpose : brings an asynchronous level into the clk domain. Kept as a
//           separate module so other buttons can reuse it.
// Ports   : clk - system clock
//           rst - synchronous, active-high reset (both flops to 0)
//           d   - asynchronous input level
//           q   - synchronised level, two clk edges behind d

module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button conditioner producing one clean ld pulse per press
//
// Purpose : synchronises a raw key, debounces press and release, and
//           optionally auto-repeats while the key is held. ld drives the
//           counter's load/count input directly.
// Ports   : clk       - system clock
//           rst       - synchronous, active-high reset
//           key_in    - raw button, asynchronous, active-high
//           repeat_en - enables auto-repeat (synchronous level)
//           ld        - one-cycle count pulse, registered
//           pressed   - debounced key level, registered
//           repeating - high while the FSM is auto-repeating, registered

module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_N    = DEF_DEBOUNCE_N,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic repeat_en,
  output logic ld,
  output logic pressed,
  output logic repeating
);

  // One counter serves all timed states; it only ever reaches terminal-1 of
  // the largest interval, so $clog2 of that interval is enough bits.
  localparam int unsigned CNT_MAX = max3(DEBOUNCE_N, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_N - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             key_s2;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             ld_q;
  logic             pressed_q;
  logic             repeating_q;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_s2)
  );

  assign cnt_inc_d = cnt_q + CNT_W'(1);

  // In every timed state the key level is tested before the terminal count,
  // so a key change coinciding with a terminal suppresses the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ld_q        <= 1'b0;
      pressed_q   <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      ld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_s2) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end

        ST_PRESS_WAIT: begin
          if (!key_s2) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q   <= ST_HELD;
            cnt_q     <= '0;
            pressed_q <= 1'b1;
            ld_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        ST_HELD: begin
          if (!key_s2) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= '0;
          end else if (repeat_en) begin
            if (cnt_q == DLY_LAST) begin
              state_q     <= ST_REPEAT;
              cnt_q       <= '0;
              ld_q        <= 1'b1;
              repeating_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end else begin
            // Disabling repeat restarts the full delay when it is re-enabled.
            cnt_q <= '0;
          end
        end

        ST_REPEAT: begin
          if (!key_s2) begin
            state_q     <= ST_RELEASE_WAIT;
            cnt_q       <= '0;
            repeating_q <= 1'b0;
          end else if (!repeat_en) begin
            state_q     <= ST_HELD;
            cnt_q       <= '0;
            repeating_q <= 1'b0;
          end else if (cnt_q == PER_LAST) begin
            cnt_q <= '0;
            ld_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        ST_RELEASE_WAIT: begin
          // A return to high here is release bounce: back to HELD, no pulse.
          if (key_s2) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          pressed_q   <= 1'b0;
          repeating_q <= 1'b0;
        end
      endcase
    end
  end

  assign ld        = ld_q;
  assign pressed   = pressed_q;
  assign repeating = repeating_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce
//
// Purpose : directed scenarios plus randomized key/repeat/reset stimulus,
//           compared each cycle against a run-length reference model.
// Ports   : none (top-level bench)

module tb_key_debounce;

  localparam int DEB_N = 4;
  localparam int RD    = 8;
  localparam int RP    = 3;

  logic clk;
  logic rst;
  logic key_in;
  logic repeat_en;
  logic ld;
  logic pressed;
  logic repeating;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: key level seen two edges late; press/release accepted
  // after DEB_N+1 consecutive samples of the new level; repeat pulses after
  // RD consecutive enabled held samples, then every RP.
  bit m_s1, m_s2, m_ld, m_pressed, m_rep;
  int hi_run, lo_run, hold_cnt;

  key_debounce #(
    .DEBOUNCE_N    (DEB_N),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .repeat_en (repeat_en),
    .ld        (ld),
    .pressed   (pressed),
    .repeating (repeating)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    bit s;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_ld = 0; m_pressed = 0; m_rep = 0;
      hi_run = 0; lo_run = 0; hold_cnt = 0;
      return;
    end
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = key_in;
    m_ld = 0;
    if (!m_pressed) begin
      hi_run = s ? hi_run + 1 : 0;
      if (hi_run == DEB_N + 1) begin
        m_pressed = 1; m_ld = 1; hi_run = 0; lo_run = 0; hold_cnt = 0;
      end
    end else if (!s) begin
      m_rep = 0; hold_cnt = 0; lo_run++;
      if (lo_run == DEB_N + 1) begin
        m_pressed = 0; lo_run = 0;
      end
    end else if (lo_run != 0) begin
      lo_run = 0; hold_cnt = 0;
    end else if (!repeat_en) begin
      m_rep = 0; hold_cnt = 0;
    end else begin
      hold_cnt++;
      if (!m_rep && hold_cnt == RD) begin
        m_rep = 1; m_ld = 1; hold_cnt = 0;
      end else if (m_rep && hold_cnt == RP) begin
        m_ld = 1; hold_cnt = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; key_in = 1; repeat_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({ld, pressed, repeating} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=000", i, {ld, pressed, repeating});
      end
    end
    rst = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_cmp++;
      if (ld !== (e == 6) || {ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL reset_press e=%0d got=%b model=%b", e, {ld, pressed, repeating}, {m_ld, m_pressed, m_rep});
      end
    end
    key_in = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_cmp++;
      if ({ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL reset_release e=%0d got=%b exp=%b", e, {ld, pressed, repeating}, {m_ld, m_pressed, m_rep});
      end
    end
  endtask

  task automatic test_clean_press();
    key_in = 1; repeat_en = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      n_cmp++;
      if (ld !== (e == 6) || pressed !== (e >= 6) || repeating !== 1'b0 ||
          {ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL clean_press e=%0d got=%b model=%b", e, {ld, pressed, repeating}, {m_ld, m_pressed, m_rep});
      end
    end
    key_in = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_cmp++;
      if (ld !== 1'b0 || pressed !== (e < 6) ||
          {ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL clean_release e=%0d got=%b model=%b", e, {ld, pressed, repeating}, {m_ld, m_pressed, m_rep});
      end
    end
  endtask

  task automatic test_press_bounce();
    repeat_en = 0;
    for (int e = 0; e < 12; e++) begin
      key_in = (e < 2);
      tick();
      n_cmp++;
      if ({ld, pressed, repeating} !== 3'b000 ||
          {ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL press_bounce e=%0d got=%b exp=000", e, {ld, pressed, repeating});
      end
    end
  endtask

  task automatic test_auto_repeat();
    key_in = 1; repeat_en = 1;
    for (int e = 0; e < 25; e++) begin
      tick();
      n_cmp++;
      if (ld !== (e inside {6, 14, 17, 20, 23}) || repeating !== (e >= 14) ||
          {ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL auto_repeat e=%0d got=%b model=%b", e, {ld, pressed, repeating}, {m_ld, m_pressed, m_rep});
      end
    end
    key_in = 0;
    // The key is seen two edges late, so one period-aligned pulse (edge 26) remains.
    for (int r = 0; r < 10; r++) begin
      tick();
      n_cmp++;
      if (ld !== (r == 1) || {ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL repeat_release r=%0d got=%b model=%b", r, {ld, pressed, repeating}, {m_ld, m_pressed, m_rep});
      end
    end
    repeat_en = 0;
  endtask

  task automatic test_release_bounce();
    key_in = 1; repeat_en = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_cmp++;
      if ({ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL rel_bounce_press e=%0d got=%b exp=%b", e, {ld, pressed, repeating}, {m_ld, m_pressed, m_rep});
      end
    end
    for (int r = 0; r < 15; r++) begin
      key_in = (r == 2);
      tick();
      n_cmp++;
      if (ld !== 1'b0 || pressed !== (r < 9) ||
          {ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL release_bounce r=%0d got=%b model=%b", r, {ld, pressed, repeating}, {m_ld, m_pressed, m_rep});
      end
    end
  endtask

  task automatic test_reset_in_repeat();
    key_in = 1; repeat_en = 1;
    for (int e = 0; e < 16; e++) begin
      tick();
      n_cmp++;
      if ({ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL rst_repeat_run e=%0d got=%b exp=%b", e, {ld, pressed, repeating}, {m_ld, m_pressed, m_rep});
      end
    end
    rst = 1;
    for (int e = 16; e < 18; e++) begin
      tick();
      n_cmp++;
      if ({ld, pressed, repeating} !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_in_repeat e=%0d got=%b exp=000", e, {ld, pressed, repeating});
      end
    end
    rst = 0; key_in = 0; repeat_en = 0;
    for (int e = 0; e < 4; e++) begin
      tick();
      n_cmp++;
      if ({ld, pressed, repeating} !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_after e=%0d got=%b exp=000", e, {ld, pressed, repeating});
      end
    end
  endtask

  task automatic test_random();
    int  seg;
    bit  prev_ld;
    seg     = 0;
    prev_ld = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        key_in = ~key_in;
        seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                          : int'($urandom_range(4, 30));
      end
      seg--;
      if ($urandom_range(0, 39) == 0) repeat_en = ~repeat_en;
      rst = ($urandom_range(0, 299) == 0);
      tick();
      n_cmp++;
      if ({ld, pressed, repeating} !== {m_ld, m_pressed, m_rep}) begin
        n_fail++;
        $display("FAIL random i=%0d got=%b exp=%b", i, {ld, pressed, repeating}, {m_ld, m_pressed, m_rep});
      end
      n_cmp++;
      if (ld === 1'b1 && prev_ld) begin
        n_fail++;
        $display("FAIL ld_back_to_back i=%0d got=11 exp=not both 1", i);
      end
      prev_ld = (ld === 1'b1);
    end
    rst = 0; key_in = 0; repeat_en = 0;
  endtask

  initial begin
    rst = 1; key_in = 0; repeat_en = 0;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_clean_press();
    test_auto_repeat();
    test_release_bounce();
    test_reset_in_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
